// File: rtl/ble4_cfg_ctrl.sv
// Configuration sequencer for NUM_BLE ble4 tiles: turns a valid/ready bitstream into
// one-cycle enable/address/data_in write strobes, LUT bits first then output-mux bits per BLE.
module ble4_cfg_ctrl #(
  parameter int NUM_BLE     = 4,
  parameter int LUT_BITS    = 16,
  parameter int MUX_BITS    = 3,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W      = (NUM_BLE > 1) ? $clog2(NUM_BLE) : 1,
  localparam int TO_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             cfg_enable,
  output logic [0:4]       cfg_address,
  output logic             cfg_data_in,
  output logic [SEL_W-1:0] ble_sel,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_LUT,
    S_LOAD_MUX,
    S_FINISH
  } state_e;

  localparam logic [3:0]       LUT_LAST = 4'(LUT_BITS - 1);
  localparam logic [3:0]       MUX_LAST = 4'(MUX_BITS - 1);
  localparam logic [SEL_W-1:0] BLE_LAST = SEL_W'(NUM_BLE - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0] ble_idx_q, ble_idx_d;
  logic [SEL_W-1:0] ble_sel_q, ble_sel_d;
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [TO_W-1:0]  idle_inc;
  logic             enable_q, enable_d;
  logic [4:0]       address_q, address_d;
  logic             data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;

  // State register: every flop, including the strobe, clears asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      ble_idx_q  <= '0;
      ble_sel_q  <= '0;
      idle_cnt_q <= '0;
      enable_q   <= 1'b0;
      address_q  <= '0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ble_idx_q  <= ble_idx_d;
      ble_sel_q  <= ble_sel_d;
      idle_cnt_q <= idle_cnt_d;
      enable_q   <= enable_d;
      address_q  <= address_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign xfer     = bit_valid & bit_ready;
  assign idle_inc = (idle_cnt_q == TO_LIMIT) ? idle_cnt_q : idle_cnt_q + TO_W'(1);

  // Next-state logic.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ble_idx_d  = ble_idx_q;
    ble_sel_d  = ble_sel_q;
    idle_cnt_d = idle_cnt_q;
    enable_d   = 1'b0;
    address_d  = address_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d    = S_LOAD_LUT;
          bit_cnt_d  = '0;
          ble_idx_d  = '0;
          ble_sel_d  = '0;
          idle_cnt_d = '0;
          err_d      = 1'b0;
        end
      end

      S_LOAD_LUT, S_LOAD_MUX: begin
        if (cfg_abort) begin
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          ble_idx_d  = '0;
          ble_sel_d  = '0;
          idle_cnt_d = '0;
        end else if (xfer) begin
          // ble_sel tracks the BLE of the strobe, not the BLE the counters point at next.
          enable_d   = 1'b1;
          data_d     = bit_data;
          ble_sel_d  = ble_idx_q;
          idle_cnt_d = '0;
          if (state_q == S_LOAD_LUT) begin
            address_d = {bit_cnt_q, 1'b0};
            if (bit_cnt_q == LUT_LAST) begin
              bit_cnt_d = '0;
              state_d   = S_LOAD_MUX;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            address_d = {bit_cnt_q[1:0], 3'b001};
            if (bit_cnt_q == MUX_LAST) begin
              bit_cnt_d = '0;
              if (ble_idx_q == BLE_LAST) begin
                state_d = S_FINISH;
              end else begin
                ble_idx_d = ble_idx_q + SEL_W'(1);
                state_d   = S_LOAD_LUT;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end else if (TIMEOUT_CYC != 0) begin
          idle_cnt_d = idle_inc;
          if (idle_inc == TO_LIMIT) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            bit_cnt_d = '0;
            ble_idx_d = '0;
            ble_sel_d = '0;
          end
        end
      end

      S_FINISH: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        ble_idx_d = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    bit_ready   = ((state_q == S_LOAD_LUT) || (state_q == S_LOAD_MUX)) && !cfg_abort;
    cfg_busy    = (state_q != S_IDLE);
    cfg_enable  = enable_q;
    cfg_address = address_q;
    cfg_data_in = data_q;
    ble_sel     = ble_sel_q;
    cfg_done    = done_q;
    cfg_err     = err_q;
  end

endmodule

// File: tb/tb_ble4_cfg_ctrl.sv
// Scoreboard bench for ble4_cfg_ctrl: the driver pushes expected strobes on each accepted
// bit, an independent monitor pops and compares whenever cfg_enable is seen.
module tb_ble4_cfg_ctrl;

  localparam int NUM_BLE  = 4;
  localparam int TIMEOUT  = 8;
  localparam int RUN_BITS = 19 * NUM_BLE;

  typedef struct {
    logic [4:0] addr;
    logic       data;
    int         sel;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_start, cfg_abort, bit_valid, bit_data;
  logic       bit_ready, cfg_enable, cfg_data_in, cfg_busy, cfg_done, cfg_err;
  logic [0:4] cfg_address;
  logic [1:0] ble_sel;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_xfer = 0;
  int   bit_k = 0;

  ble4_cfg_ctrl #(
    .NUM_BLE    (NUM_BLE),
    .LUT_BITS   (16),
    .MUX_BITS   (3),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_ready  (bit_ready),
    .cfg_enable (cfg_enable),
    .cfg_address(cfg_address),
    .cfg_data_in(cfg_data_in),
    .ble_sel    (ble_sel),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: independent of the driver, compares every strobe against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (cfg_enable) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got address %0d with empty scoreboard (cycle %0d)",
                 cfg_address, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_addr", 32'(cfg_address), 32'(e.addr));
        check("strobe_data", 32'(cfg_data_in), 32'(e.data));
        check("strobe_sel", 32'(ble_sel), e.sel);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
    if (cfg_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_with_done", 32'(cfg_busy), 0);
    end
  end

  // Expected strobe for run bit k: 16 LUT bits at 2*j, then mux bits at 8*(j-16)+1.
  function automatic exp_t expect_bit(input int k, input logic b, input int at);
    exp_t e;
    int   j;
    j      = k % 19;
    e.addr = (j < 16) ? 5'(j * 2) : 5'((j - 16) * 8 + 1);
    e.data = b;
    e.sel  = k / 19;
    e.cyc  = at;
    return e;
  endfunction

  task automatic start_run();
    @(negedge clk);
    cfg_start = 1'b1;
    bit_valid = 1'b0;
    bit_k     = 0;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    check("busy_after_start", 32'(cfg_busy), 1);
  endtask

  // Sends n bits (pattern 1010..), gap idle cycles between bits, start pulse at bit start_at.
  task automatic send_bits(input int n, input int gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_data  = (bit_k % 2 == 0);
      cfg_start = (i == start_at);
      #1;
      check("bit_ready", 32'(bit_ready), 1);
      if (bit_ready) begin
        sb.push_back(expect_bit(bit_k, bit_data, cyc + 1));
        last_xfer = cyc;
        bit_k++;
      end
      @(posedge clk);
      if (i < n - 1) begin
        repeat (gap) begin
          @(negedge clk);
          bit_valid = 1'b0;
          cfg_start = 1'b0;
          @(posedge clk);
        end
      end
    end
  endtask

  task automatic finish_run(input int n_bits, input int s0, input int d0);
    int waited;
    waited = 0;
    @(negedge clk);
    bit_valid = 1'b0;
    cfg_start = 1'b0;
    #1;
    while (done_cnt == d0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    repeat (2) @(negedge clk);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("done_latency", done_cyc, last_xfer + 2);
    check("strobe_count", strobe_cnt - s0, n_bits);
    check("scoreboard_empty", sb.size(), 0);
    check("busy_after_done", 32'(cfg_busy), 0);
  endtask

  initial begin
    int s0, d0;
    reset     = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    #1;
    check("rst_enable", 32'(cfg_enable), 0);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_ready", 32'(bit_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_address", 32'(cfg_address), 0);
    check("rst_ble_sel", 32'(ble_sel), 0);
    check("rst_done", 32'(cfg_done), 0);
    check("rst_err", 32'(cfg_err), 0);

    // Back-to-back run across all BLEs: no bubble at LUT->mux or BLE->BLE.
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    send_bits(RUN_BITS, 0, -1);
    finish_run(RUN_BITS, s0, d0);

    // bit_valid toggling every other cycle.
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    send_bits(RUN_BITS, 1, -1);
    finish_run(RUN_BITS, s0, d0);
    check("err_after_toggle_run", 32'(cfg_err), 0);

    // Abort after 7 LUT bits, during the 7th strobe cycle.
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    send_bits(7, 0, -1);
    @(negedge clk);
    cfg_abort = 1'b1;
    bit_valid = 1'b1;
    #1 check("ready_during_abort", 32'(bit_ready), 0);
    @(posedge clk);
    #1;
    cfg_abort = 1'b0;
    bit_valid = 1'b0;
    check("busy_after_abort", 32'(cfg_busy), 0);
    check("ready_after_abort", 32'(bit_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_strobes", strobe_cnt - s0, 7);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb_empty", sb.size(), 0);
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    send_bits(RUN_BITS, 0, -1);
    finish_run(RUN_BITS, s0, d0);

    // Timeout: stall after 3 bits; error exactly after TIMEOUT idle cycles.
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    send_bits(3, 0, -1);
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    #1;
    check("err_before_timeout", 32'(cfg_err), 0);
    check("busy_before_timeout", 32'(cfg_busy), 1);
    @(negedge clk);
    #1;
    check("err_at_timeout", 32'(cfg_err), 1);
    check("busy_at_timeout", 32'(cfg_busy), 0);
    check("ready_at_timeout", 32'(bit_ready), 0);
    check("timeout_strobes", strobe_cnt - s0, 3);
    check("timeout_no_done", done_cnt - d0, 0);

    // Next start clears the error; a start pulse mid-run is ignored.
    s0 = strobe_cnt; d0 = done_cnt;
    start_run();
    check("err_cleared", 32'(cfg_err), 0);
    send_bits(RUN_BITS, 0, 10);
    finish_run(RUN_BITS, s0, d0);

    // Reset asserted in a strobe cycle drops outputs immediately.
    start_run();
    send_bits(5, 0, -1);
    #1 check("enable_before_reset", 32'(cfg_enable), 1);
    reset = 1'b0;
    #1;
    check("enable_in_reset", 32'(cfg_enable), 0);
    check("busy_in_reset", 32'(cfg_busy), 0);
    check("ready_in_reset", 32'(bit_ready), 0);
    sb.delete();
    bit_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_address", 32'(cfg_address), 0);
    check("post_reset_sel", 32'(ble_sel), 0);
    check("post_reset_enable", 32'(cfg_enable), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
